// File: rtl/abs_stream.sv
// Streaming per-lane absolute-value unit: two-stage valid/ready pipeline with
// abs / pass / neg-abs / sign-only modes and a saturating overflow counter.
module abs_stream #(
    parameter int WIDTH = 32,
    parameter int LANES = 1,
    parameter int SAT   = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [1:0]             mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_sign,
    output logic [LANES-1:0]       out_ovf,
    output logic [15:0]            ovf_count
);

    typedef enum logic [1:0] {
        MODE_ABS     = 2'b00,
        MODE_PASS    = 2'b01,
        MODE_NEG_ABS = 2'b10,
        MODE_SIGN    = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_VAL = ~MIN_VAL;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic                   en;
    logic                   s1_valid;
    logic [LANES*WIDTH-1:0] s1_data;
    mode_e                  s1_mode;
    logic [LANES*WIDTH-1:0] res_data;
    logic [LANES-1:0]       res_sign;
    logic [LANES-1:0]       res_ovf;

    // One enable moves the whole pipe, so a stalled output freezes both stages.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    function automatic logic [WIDTH-1:0] lane_result(input logic [WIDTH-1:0] x,
                                                     input mode_e m);
        logic             neg;
        logic [WIDTH-1:0] mag;
        logic [WIDTH-1:0] r;
        neg = x[WIDTH-1];
        mag = neg ? (~x + ONE) : x;
        if (SAT != 0 && x == MIN_VAL) mag = MAX_VAL;
        case (m)
            MODE_ABS:     r = mag;
            MODE_PASS:    r = x;
            // The most-negative value negates to itself, so -|x| needs no clamp.
            MODE_NEG_ABS: r = neg ? x : (~x + ONE);
            default:      r = neg ? '1 : ((x == '0) ? '0 : ONE);
        endcase
        return r;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        res_data = '0;
        res_sign = '0;
        res_ovf  = '0;
        for (int k = 0; k < LANES; k++) begin
            res_data[k*WIDTH +: WIDTH] = lane_result(s1_data[k*WIDTH +: WIDTH], s1_mode);
            res_sign[k]                = s1_data[k*WIDTH + WIDTH - 1];
            res_ovf[k]                 = (s1_data[k*WIDTH +: WIDTH] == MIN_VAL);
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= MODE_ABS;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_data  <= in_data;
            s1_mode  <= mode_e'(mode);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sign  <= '0;
            out_ovf   <= '0;
        end else if (en) begin
            out_valid <= s1_valid;
            out_data  <= res_data;
            out_sign  <= res_sign;
            out_ovf   <= res_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (out_valid && out_ready && (|out_ovf) && ovf_count != 16'hFFFF) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_abs_stream.sv
// Bench for abs_stream: two 4-lane instances (SAT=0 and SAT=1) share stimulus;
// a valid-pipeline model plus per-instance expected-result queues check every cycle.
module tb_abs_stream;

    localparam int W  = 32;
    localparam int L  = 4;
    localparam int DW = W * L;

    typedef struct {
        logic [DW-1:0] data;
        logic [L-1:0]  sign;
        logic [L-1:0]  ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] in_data;
    logic [1:0]    mode;

    logic          in_ready0, out_valid0, in_ready1, out_valid1;
    logic [DW-1:0] out_data0, out_data1;
    logic [L-1:0]  out_sign0, out_ovf0, out_sign1, out_ovf1;
    logic [15:0]   ovf_count0, ovf_count1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   v1, v2;
    int   cnt0, cnt1;

    always #5 clk = ~clk;

    abs_stream #(.WIDTH(W), .LANES(L), .SAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .mode(mode), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_sign(out_sign0), .out_ovf(out_ovf0), .ovf_count(ovf_count0)
    );

    abs_stream #(.WIDTH(W), .LANES(L), .SAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .mode(mode), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_sign(out_sign1), .out_ovf(out_ovf1), .ovf_count(ovf_count1)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference lane function in wide signed arithmetic.
    function automatic logic [W-1:0] ref_lane(input logic [W-1:0] x, input logic [1:0] m,
                                              input bit sat);
        longint sx, a, r;
        sx = longint'($signed(x));
        a  = (sx < 0) ? -sx : sx;
        case (m)
            2'b00:   r = (sat && a > 64'sh7FFF_FFFF) ? 64'sh7FFF_FFFF : a;
            2'b01:   r = sx;
            2'b10:   r = -a;
            default: r = (sx > 0) ? 1 : ((sx == 0) ? 0 : -1);
        endcase
        return r[W-1:0];
    endfunction

    function automatic exp_t model(input logic [DW-1:0] d, input logic [1:0] m, input bit sat);
        exp_t e;
        for (int k = 0; k < L; k++) begin
            e.data[k*W +: W] = ref_lane(d[k*W +: W], m, sat);
            e.sign[k]        = d[k*W + W - 1];
            e.ovf[k]         = (d[k*W +: W] == 32'h8000_0000);
        end
        return e;
    endfunction

    task automatic cmp_side(input string nm, input logic ov, input logic ir,
                            input logic [DW-1:0] d, input logic [L-1:0] s, input logic [L-1:0] o,
                            input logic [15:0] c, input int c_exp, input bit en_m, input exp_t f);
        chk({nm, ".out_valid"}, DW'(ov), DW'(v2));
        chk({nm, ".in_ready"}, DW'(ir), DW'(en_m));
        chk({nm, ".ovf_count"}, DW'(c), DW'(c_exp));
        if (v2) begin
            chk({nm, ".out_data"}, d, f.data);
            chk({nm, ".out_sign"}, DW'(s), DW'(f.sign));
            chk({nm, ".out_ovf"}, DW'(o), DW'(f.ovf));
        end
    endtask

    // One clock: compare at the falling edge, then advance the model across the rising edge.
    task automatic tick(output bit acc);
        bit   en_m;
        exp_t f0, f1;
        @(negedge clk);
        en_m = !v2 || out_ready;
        f0 = '{default: '0};
        f1 = '{default: '0};
        if (v2) begin
            if (q0.size() == 0 || q1.size() == 0) chk("queue_nonempty", DW'(0), DW'(1));
            else begin
                f0 = q0[0];
                f1 = q1[0];
            end
        end
        cmp_side("sat0", out_valid0, in_ready0, out_data0, out_sign0, out_ovf0, ovf_count0, cnt0, en_m, f0);
        cmp_side("sat1", out_valid1, in_ready1, out_data1, out_sign1, out_ovf1, ovf_count1, cnt1, en_m, f1);
        if (v2 && out_ready && q0.size() > 0 && q1.size() > 0) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
            if (|f0.ovf && cnt0 < 65535) cnt0++;
            if (|f1.ovf && cnt1 < 65535) cnt1++;
        end
        acc = in_valid && en_m;
        if (acc) begin
            q0.push_back(model(in_data, mode, 1'b0));
            q1.push_back(model(in_data, mode, 1'b1));
        end
        if (en_m) begin
            v2 = v1;
            v1 = acc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [1:0] m);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        for (int k = 0; k < 100 && !acc; k++) tick(acc);
        if (!acc) chk("send_accepted", DW'(0), DW'(1));
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst.out_valid0", DW'(out_valid0), DW'(0));
        chk("rst.out_valid1", DW'(out_valid1), DW'(0));
        chk("rst.in_ready0", DW'(in_ready0), DW'(1));
        chk("rst.ovf_count0", DW'(ovf_count0), DW'(0));
        chk("rst.ovf_count1", DW'(ovf_count1), DW'(0));
        chk("rst.out_data0", out_data0, DW'(0));
        chk("rst.flags0", DW'({out_sign0, out_ovf0}), DW'(0));
        q0.delete();
        q1.delete();
        v1   = 1'b0;
        v2   = 1'b0;
        cnt0 = 0;
        cnt1 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit            acc;
        int            i;
        logic [DW-1:0] samp[10];

        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        mode      = 2'b00;
        #2;
        do_reset();

        // abs of the boundary values, back to back
        send({32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000}, 2'b00);
        send({32'h8000_0000, 32'h0000_0000, 32'hC000_0000, 32'h0000_0000}, 2'b00);
        send({32'h7FFF_FFFF, 32'h8000_0001, 32'h0000_0000, 32'h7FFF_FFFF}, 2'b00);
        repeat (3) tick(acc);

        // neg-abs, sign-only and pass
        send({32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF}, 2'b10);
        send({32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'hFFFF_FFF0}, 2'b11);
        send({32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0005, 32'h0000_0000}, 2'b11);
        send({32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0005}, 2'b11);
        send({32'hDEAD_BEEF, 32'h8000_0000, 32'h0000_0000, 32'h1357_9BDF}, 2'b01);
        repeat (3) tick(acc);

        // ten samples with a five-cycle downstream stall in the middle
        for (int k = 0; k < 10; k++)
            samp[k] = {$urandom(), $urandom(), (k == 3) ? 32'h8000_0000 : $urandom(), $urandom()};
        i = 0;
        for (int cyc = 0; cyc < 80 && i < 10; cyc++) begin
            in_valid  = 1'b1;
            in_data   = samp[i];
            mode      = 2'(i);
            out_ready = !(cyc >= 4 && cyc < 9);
            tick(acc);
            if (acc) i++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_accepted", DW'(i), DW'(10));
        repeat (3) tick(acc);

        // random traffic and back-pressure
        for (int k = 0; k < 40; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            mode      = 2'($urandom_range(0, 3));
            in_data   = {$urandom(), ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom(),
                         $urandom(), ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom()};
            tick(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick(acc);

        // reset with two samples in flight
        send({32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000}, 2'b00);
        send({32'h0000_0007, 32'hFFFF_FFF9, 32'h0000_0000, 32'h8000_0000}, 2'b00);
        chk("pre_reset.out_valid0", DW'(out_valid0), DW'(v2));
        do_reset();
        repeat (5) tick(acc);

        send({32'h0000_0002, 32'hFFFF_FFFE, 32'h8000_0000, 32'h0000_0000}, 2'b00);
        repeat (4) tick(acc);
        chk("drained.q0", DW'(q0.size()), DW'(0));
        chk("drained.q1", DW'(q1.size()), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
